// File: rtl/tdc_stream_sequencer_pkg.sv
// Shared constants, state encoding and the sentinel clamp for the TDC stream sequencer.
package tdc_stream_sequencer_pkg;

  localparam int Np                = 10;
  localparam int PIXEL_NUM_PER_RAM = 3;
  localparam int DATA_NUM          = 2;

  localparam int CNT_W   = $clog2(DATA_NUM + 1);
  localparam int SLOT_W  = (DATA_NUM > 1) ? $clog2(DATA_NUM) : 1;
  localparam int DRAIN_N = PIXEL_NUM_PER_RAM * DATA_NUM;
  localparam int IDX_W   = (DRAIN_N > 1) ? $clog2(DRAIN_N) : 1;

  localparam logic [Np-1:0] NO_HIT = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  // A real timestamp must never alias the empty-slot marker.
  function automatic logic [Np-1:0] clamp_hit(input logic [Np-1:0] d);
    return (d == NO_HIT) ? (NO_HIT - 1'b1) : d;
  endfunction

endpackage

// File: rtl/tdc_stream_sequencer_slots.sv
// Per-pixel timestamp store: DATA_NUM slots filled in arrival order, with overflow strobe.
module tdc_pixel_slots
  import tdc_stream_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic              i_clear,
  input  logic              i_capture,
  input  logic              i_valid,
  input  logic [Np-1:0]     i_data,
  input  logic [SLOT_W-1:0] i_rd_idx,
  output logic [Np-1:0]     o_rd_data,
  output logic              o_ovf
);

  logic [Np-1:0]    r_slot [DATA_NUM];
  logic [CNT_W-1:0] r_cnt;
  logic             w_hit;
  logic             w_full;

  assign w_hit  = i_capture & i_valid;
  assign w_full = (r_cnt == CNT_W'(DATA_NUM));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      for (int i = 0; i < DATA_NUM; i++) r_slot[i] <= NO_HIT;
      r_cnt <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < DATA_NUM; i++) r_slot[i] <= NO_HIT;
      r_cnt <= '0;
    end else if (w_hit && !w_full) begin
      for (int i = 0; i < DATA_NUM; i++) begin
        if (r_cnt == CNT_W'(i)) r_slot[i] <= clamp_hit(i_data);
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_rd_data = r_slot[i_rd_idx];
  assign o_ovf     = w_hit & w_full;

endmodule

// File: rtl/tdc_stream_sequencer.sv
// Collects per-pixel TDC hits during a window, then drains them as a dense wrEn/data stream.
//   state   | meaning
//   IDLE    | waiting for acqStart; slots cleared on the accepting edge
//   COLLECT | capturing hits per pixel until acqEnd
//   DRAIN   | emitting PIXEL_NUM_PER_RAM*DATA_NUM words, pixel-major
module tdc_stream_sequencer
  import tdc_stream_sequencer_pkg::*;
(
  input  logic                         clk,
  input  logic                         res,
  input  logic                         acqStart,
  input  logic                         acqEnd,
  input  logic [PIXEL_NUM_PER_RAM-1:0] evValid,
  input  logic [Np-1:0]                evData [PIXEL_NUM_PER_RAM],
  input  logic                         flagClr,
  output logic                         wrEn,
  output logic [Np-1:0]                data,
  output logic                         busy,
  output logic                         frameDone,
  output logic                         hitOvf,
  output logic                         acqOvr
);

  state_t                       r_state;
  logic [IDX_W-1:0]             r_idx;
  logic                         r_wr_en;
  logic [Np-1:0]                r_data;
  logic                         r_busy;
  logic                         r_frame_done;
  logic                         r_hit_ovf;
  logic                         r_acq_ovr;

  logic                         w_clear;
  logic                         w_capture;
  logic                         w_last;
  logic [SLOT_W-1:0]            w_slot;
  logic [PIXEL_NUM_PER_RAM-1:0] w_pix_hot;
  logic [Np-1:0]                w_word;
  logic [Np-1:0]                w_rd_data [PIXEL_NUM_PER_RAM];
  logic [PIXEL_NUM_PER_RAM-1:0] w_ovf;

  assign w_clear   = (r_state == IDLE) && acqStart;
  assign w_capture = (r_state == COLLECT);
  assign w_last    = (r_idx == IDX_W'(DRAIN_N - 1));

  for (genvar p = 0; p < PIXEL_NUM_PER_RAM; p++) begin : g_pix
    tdc_pixel_slots u_slots (
      .clk       (clk),
      .res       (res),
      .i_clear   (w_clear),
      .i_capture (w_capture),
      .i_valid   (evValid[p]),
      .i_data    (evData[p]),
      .i_rd_idx  (w_slot),
      .o_rd_data (w_rd_data[p]),
      .o_ovf     (w_ovf[p])
    );
  end

  // Split the flat drain index into a shared slot address and a one-hot pixel select.
  always_comb begin
    w_slot    = '0;
    w_pix_hot = '0;
    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
      for (int s = 0; s < DATA_NUM; s++) begin
        if (r_idx == IDX_W'(p * DATA_NUM + s)) begin
          w_slot       = SLOT_W'(s);
          w_pix_hot[p] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_word = '0;
    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
      if (w_pix_hot[p]) w_word = w_rd_data[p];
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_wr_en      <= 1'b0;
      r_data       <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_data       <= '0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (acqStart) begin
            r_state <= COLLECT;
            r_busy  <= 1'b1;
          end
        end
        COLLECT: begin
          if (acqEnd) begin
            r_state <= DRAIN;
            r_idx   <= '0;
          end
        end
        DRAIN: begin
          r_wr_en      <= 1'b1;
          r_data       <= w_word;
          r_frame_done <= w_last;
          if (w_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_idx   <= '0;
        end
      endcase
    end
  end

  // Sticky flags: a set event on the same edge as flagClr keeps the flag set.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_hit_ovf <= 1'b0;
      r_acq_ovr <= 1'b0;
    end else begin
      if (|w_ovf)       r_hit_ovf <= 1'b1;
      else if (flagClr) r_hit_ovf <= 1'b0;
      if (acqStart && (r_state != IDLE)) r_acq_ovr <= 1'b1;
      else if (flagClr)                  r_acq_ovr <= 1'b0;
    end
  end

  assign wrEn      = r_wr_en;
  assign data      = r_data;
  assign busy      = r_busy;
  assign frameDone = r_frame_done;
  assign hitOvf    = r_hit_ovf;
  assign acqOvr    = r_acq_ovr;

endmodule

// File: tb/tb_tdc_stream_sequencer.sv
// Directed bench for tdc_stream_sequencer: cycle-level vector table plus hand sequences.
module tb_tdc_stream_sequencer;
  import tdc_stream_sequencer_pkg::*;

  logic                         clk = 1'b0;
  logic                         res;
  logic                         acqStart;
  logic                         acqEnd;
  logic [PIXEL_NUM_PER_RAM-1:0] evValid;
  logic [Np-1:0]                evData [PIXEL_NUM_PER_RAM];
  logic                         flagClr;
  logic                         wrEn;
  logic [Np-1:0]                data;
  logic                         busy;
  logic                         frameDone;
  logic                         hitOvf;
  logic                         acqOvr;

  int n_tests = 0;
  int n_fail  = 0;

  tdc_stream_sequencer dut (
    .clk       (clk),
    .res       (res),
    .acqStart  (acqStart),
    .acqEnd    (acqEnd),
    .evValid   (evValid),
    .evData    (evData),
    .flagClr   (flagClr),
    .wrEn      (wrEn),
    .data      (data),
    .busy      (busy),
    .frameDone (frameDone),
    .hitOvf    (hitOvf),
    .acqOvr    (acqOvr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] valid;
    logic [9:0] d0;
    logic [9:0] d1;
    logic [9:0] d2;
    logic       st;
    logic       en;
    logic       clr;
    logic       ew;
    logic [9:0] ed;
    logic       efd;
    logic       eb;
    logic       eh;
    logic       ea;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int valid, input int d0, input int d1, input int d2,
                     input int st, input int en, input int clr,
                     input int ew, input int ed, input int efd, input int eb,
                     input int eh, input int ea);
    vec_t v;
    v.valid = 3'(valid); v.d0 = 10'(d0); v.d1 = 10'(d1); v.d2 = 10'(d2);
    v.st = 1'(st); v.en = 1'(en); v.clr = 1'(clr);
    v.ew = 1'(ew); v.ed = 10'(ed); v.efd = 1'(efd); v.eb = 1'(eb);
    v.eh = 1'(eh); v.ea = 1'(ea);
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int valid, input int d0, input int d1, input int d2,
                      input int st, input int en, input int clr);
    evValid   = 3'(valid);
    evData[0] = 10'(d0);
    evData[1] = 10'(d1);
    evData[2] = 10'(d2);
    acqStart  = 1'(st);
    acqEnd    = 1'(en);
    flagClr   = 1'(clr);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_drain(input string tag, input int w0, input int w1, input int w2,
                             input int w3, input int w4, input int w5);
    int exp_w[6];
    exp_w = '{w0, w1, w2, w3, w4, w5};
    for (int i = 0; i < 6; i++) begin
      idle_step();
      check($sformatf("%s w%0d wrEn", tag, i), int'(wrEn), 1);
      check($sformatf("%s w%0d data", tag, i), int'(data), exp_w[i]);
      check($sformatf("%s w%0d frameDone", tag, i), int'(frameDone), (i == 5) ? 1 : 0);
    end
    idle_step();
    check({tag, " post wrEn"}, int'(wrEn), 0);
    check({tag, " post data"}, int'(data), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res = 1'b0; acqStart = 1'b0; acqEnd = 1'b0; evValid = '0; flagClr = 1'b0;
    for (int p = 0; p < PIXEL_NUM_PER_RAM; p++) evData[p] = '0;

    // single hit per pixel
    add(0, 0,   0,   0,   1,0,0, 0,0,   0,1,0,0);
    add(7, 108, 511, 200, 0,0,0, 0,0,   0,1,0,0);
    add(0, 0,   0,   0,   0,1,0, 0,0,   0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,108, 0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,511, 0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,200, 0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,1,0,0,0);
    add(0, 0,   0,   0,   0,0,0, 0,0,   0,0,0,0);
    // full slots plus overflow on p1, cleared mid-drain
    add(0, 0,   0,   0,   1,0,0, 0,0,   0,1,0,0);
    add(2, 0,   50,  0,   0,0,0, 0,0,   0,1,0,0);
    add(2, 0,   1000,0,   0,0,0, 0,0,   0,1,0,0);
    add(2, 0,   48,  0,   0,0,0, 0,0,   0,1,1,0);
    add(0, 0,   0,   0,   0,1,0, 0,0,   0,1,1,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,0,1,1,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,0,1,1,0);
    add(0, 0,   0,   0,   0,0,1, 1,50,  0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,1000,0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,0,1,0,0);
    add(0, 0,   0,   0,   0,0,0, 1,1023,1,0,0,0);
    add(0, 0,   0,   0,   0,0,0, 0,0,   0,0,0,0);

    #1;
    check("reset wrEn", int'(wrEn), 0);
    check("reset data", int'(data), 0);
    check("reset busy", int'(busy), 0);
    check("reset frameDone", int'(frameDone), 0);
    check("reset hitOvf", int'(hitOvf), 0);
    check("reset acqOvr", int'(acqOvr), 0);
    @(posedge clk); @(posedge clk); #1;
    res = 1'b1;
    idle_step();

    foreach (tbl[i]) begin
      step(int'(tbl[i].valid), int'(tbl[i].d0), int'(tbl[i].d1), int'(tbl[i].d2),
           int'(tbl[i].st), int'(tbl[i].en), int'(tbl[i].clr));
      check($sformatf("row%0d wrEn", i), int'(wrEn), int'(tbl[i].ew));
      check($sformatf("row%0d data", i), int'(data), int'(tbl[i].ed));
      check($sformatf("row%0d frameDone", i), int'(frameDone), int'(tbl[i].efd));
      check($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].eb));
      check($sformatf("row%0d hitOvf", i), int'(hitOvf), int'(tbl[i].eh));
      check($sformatf("row%0d acqOvr", i), int'(acqOvr), int'(tbl[i].ea));
    end

    // sentinel clamp on a hit presented in the acqEnd cycle
    step(0, 0, 0, 0, 1, 0, 0);
    step(4, 0, 0, 1023, 0, 1, 0);
    check_drain("clamp", 1023, 1023, 1023, 1023, 1022, 1023);

    // empty window
    step(0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check("empty pre wrEn", int'(wrEn), 0);
    check_drain("empty", 1023, 1023, 1023, 1023, 1023, 1023);

    // overrun during drain, then restart right after frameDone
    step(0, 0, 0, 0, 1, 0, 0);
    step(1, 77, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0, 0);
    check("ovr w0 data", int'(data), 77);
    check("ovr acqOvr set", int'(acqOvr), 1);
    for (int i = 1; i < 6; i++) begin
      idle_step();
      check($sformatf("ovr w%0d data", i), int'(data), 1023);
      check($sformatf("ovr w%0d wrEn", i), int'(wrEn), 1);
    end
    check("ovr frameDone", int'(frameDone), 1);
    step(0, 0, 0, 0, 1, 0, 0);
    check("restart busy", int'(busy), 1);
    check("restart wrEn", int'(wrEn), 0);
    step(0, 0, 0, 0, 1, 0, 1);
    check("set wins acqOvr", int'(acqOvr), 1);
    step(0, 0, 0, 0, 0, 0, 1);
    check("clr acqOvr", int'(acqOvr), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_drain("restart", 1023, 1023, 1023, 1023, 1023, 1023);

    // reset mid-drain after word 3
    step(0, 0, 0, 0, 1, 0, 0);
    step(7, 1, 2, 3, 1, 0, 0);
    step(7, 4, 5, 6, 0, 0, 0);
    step(1, 7, 0, 0, 0, 0, 0);
    check("pre-reset hitOvf", int'(hitOvf), 1);
    check("pre-reset acqOvr", int'(acqOvr), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    idle_step(); check("rst w0 data", int'(data), 1);
    idle_step(); check("rst w1 data", int'(data), 4);
    idle_step(); check("rst w2 data", int'(data), 2);
    #2;
    res = 1'b0;
    #1;
    check("async rst wrEn", int'(wrEn), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst hitOvf", int'(hitOvf), 0);
    check("async rst acqOvr", int'(acqOvr), 0);
    @(posedge clk); #1;
    res = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle_step();
      check($sformatf("post-rst%0d frameDone", i), int'(frameDone), 0);
      check($sformatf("post-rst%0d wrEn", i), int'(wrEn), 0);
    end
    step(0, 0, 0, 0, 1, 0, 0);
    step(7, 300, 500, 90, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    check_drain("after-rst", 300, 1023, 500, 1023, 90, 1023);
    check("final hitOvf", int'(hitOvf), 0);
    check("final acqOvr", int'(acqOvr), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
